// File: rtl/tanh_pkg.sv
// tanh_pkg: FSM state codes, mode encoding and Q-format coefficient helpers for tanh_poly_unit
package tanh_pkg;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ABS  = 3'd1;
    localparam logic [2:0] ST_SQ   = 3'd2;
    localparam logic [2:0] ST_HORN = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_SIGN = 3'd5;
    localparam logic [2:0] ST_OUT  = 3'd6;

    localparam logic MODE_TANH    = 1'b0;
    localparam logic MODE_SIGMOID = 1'b1;

    // longint'() of a real rounds to nearest, ties away from zero
    function automatic longint to_q(input real c, input int frac);
        return longint'(c * (2.0 ** frac));
    endfunction

    // Odd Taylor coefficients of tanh: 1, -1/3, 2/15, -17/315, 62/2835
    function automatic longint coef_q(input int idx, input int frac);
        return to_q(idx == 0 ? 1.0 : idx == 1 ? -1.0 / 3.0 : idx == 2 ? 2.0 / 15.0 :
                    idx == 3 ? -17.0 / 315.0 : 62.0 / 2835.0, frac);
    endfunction

    function automatic longint sat_q(input int frac);
        return to_q(1.3, frac);
    endfunction
endpackage

// File: rtl/tanh_fx_mul.sv
// tanh_fx_mul: signed WxW multiply keeping bits [W+FRAC-1:FRAC] of the full 2W-bit product
module tanh_fx_mul #(
    parameter int W    = 32,
    parameter int FRAC = 26
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic [2*W-1:0] p;
    logic unused_p;
    // sign-extended operands make the low 2W bits of the unsigned product the signed product
    assign p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    assign y = p[W+FRAC-1:FRAC];
    assign unused_p = ^{p[2*W-1:W+FRAC], p[FRAC-1:0]};
endmodule

// File: rtl/tanh_poly_unit.sv
// tanh_poly_unit: Horner-series tanh with clamping on one shared multiplier; sigmoid mode under TANH_SIGMOID_EN
module tanh_poly_unit
    import tanh_pkg::*;
#(
    parameter int W     = 32,
    parameter int FRAC  = 26,
    parameter int TERMS = 5,
    parameter logic [W-1:0] SAT = W'(sat_q(FRAC))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         locked,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam logic [W-1:0] K0   = W'(coef_q(0, FRAC));
    localparam logic [W-1:0] K1   = W'(coef_q(1, FRAC));
    localparam logic [W-1:0] K2   = W'(coef_q(2, FRAC));
    localparam logic [W-1:0] K3   = W'(coef_q(3, FRAC));
    localparam logic [W-1:0] K4   = W'(coef_q(4, FRAC));
    localparam logic [W-1:0] KTOP = W'(coef_q(TERMS - 1, FRAC));
    localparam logic [W-1:0] ONE  = W'(longint'(1) << FRAC);
    localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

    logic [2:0]   state;
    logic [2:0]   i;
    logic [W-1:0] x, x2, acc;
    logic         s;
    logic [W-1:0] x_in, m, k_i, ma, mb, prod, t, res;

    assign in_ready  = state == ST_IDLE && !locked && !rst;
    assign out_valid = state == ST_OUT && !locked && !rst;

    // -2^(W-1) has no positive twin, so it saturates to the largest positive value
    assign m   = !x[W-1] ? x : x == MINN ? MAXP : -x;
    assign k_i = i == 3'd0 ? K0 : i == 3'd1 ? K1 : i == 3'd2 ? K2 : i == 3'd3 ? K3 : K4;
    assign ma  = state == ST_SQ ? x : acc;
    assign mb  = state == ST_HORN ? x2 : x;
    assign t   = s ? -acc : acc;

    tanh_fx_mul #(.W(W), .FRAC(FRAC)) u_mul (.a(ma), .b(mb), .y(prod));

`ifdef TANH_SIGMOID_EN
    logic         md;
    logic [W-1:0] sum;
    assign x_in = mode == MODE_SIGMOID ? {in_data[W-1], in_data[W-1:1]} : in_data;
    assign sum  = ONE + t;
    assign res  = md == MODE_SIGMOID ? {sum[W-1], sum[W-1:1]} : t;
    always_ff @(posedge clk)
        if (in_ready && in_valid) md <= mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign x_in = in_data;
    assign res  = t;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            out_data <= '0;
        end else if (locked) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    x     <= x_in;
                    state <= ST_ABS;
                end
                ST_ABS: begin
                    s     <= x[W-1];
                    x     <= m;
                    acc   <= ONE;
                    state <= m > SAT ? ST_SIGN : ST_SQ;
                end
                ST_SQ: begin
                    x2    <= prod;
                    acc   <= KTOP;
                    i     <= 3'(TERMS - 2);
                    state <= ST_HORN;
                end
                ST_HORN: begin
                    acc   <= k_i + prod;
                    i     <= i - 3'd1;
                    state <= i == 3'd0 ? ST_FIN : ST_HORN;
                end
                ST_FIN: begin
                    acc   <= prod;
                    state <= ST_SIGN;
                end
                ST_SIGN: begin
                    out_data <= res;
                    state    <= ST_OUT;
                end
                ST_OUT: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
